// File: rtl/bm_reg_pkg.sv
// Buffer-manager register bank: address map, CTRL bit positions,
// PIO FSM encoding and a block-decode helper.
package bm_reg_pkg;

   localparam logic [7:0] BM_CTRL       = 8'h00;
   localparam logic [7:0] BM_OVF        = 8'h01;
   localparam logic [7:0] BM_CNT_BASE   = 8'h10;
   localparam logic [7:0] BM_ALPHA_BASE = 8'h20;

   localparam int CTRL_INIT = 0;
   localparam int CTRL_SNAP = 1;
   localparam int CTRL_RDSH = 2;
   localparam int CTRL_CLR  = 3;
   localparam int CTRL_SAT  = 4;
   localparam int CTRL_DONE = 31;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_RESP = 2'd2
   } bm_state_e;

   // True when a lies in the 16-entry block at base and its index is below n.
   function automatic logic bm_in_blk(
      input logic [7:0] a,
      input logic [7:0] base,
      input int         n
   );
      return (a[7:4] == base[7:4]) && (int'({28'd0, a[3:0]}) < n);
   endfunction

endpackage

// File: rtl/bm_evt_cnt.sv
// One event counter: live value with wrap/saturate, snapshot shadow,
// clear-on-read and a sticky overflow flag with write-1-to-clear.
module bm_evt_cnt #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_inc,
   input  logic             i_sat,
   input  logic             i_clr,
   input  logic             i_snap,
   input  logic             i_w1c,
   output logic [CNT_W-1:0] o_live,
   output logic [CNT_W-1:0] o_shadow,
   output logic             o_ovf
);

   localparam logic [CNT_W-1:0] MAX = '1;

   logic [CNT_W-1:0] r_live;
   logic [CNT_W-1:0] r_shad;
   logic             r_ovf;
   logic             w_max;

   assign w_max    = (r_live == MAX);
   assign o_live   = r_live;
   assign o_shadow = r_shad;
   assign o_ovf    = r_ovf;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_live <= '0;
         r_shad <= '0;
         r_ovf  <= 1'b0;
      end else begin
         // A clear racing an increment leaves that increment counted.
         if (i_clr)
            r_live <= i_inc ? CNT_W'(1) : '0;
         else if (i_inc)
            r_live <= w_max ? (i_sat ? MAX : '0) : r_live + CNT_W'(1);
         if (i_inc && w_max)
            r_ovf <= 1'b1;
         else if (i_w1c)
            r_ovf <= 1'b0;
         if (i_snap)
            r_shad <= r_live;
      end
   end

endmodule

// File: rtl/bm_reg_bank.sv
// PIO register bank for the buffer manager: event counters, per-queue
// alpha thresholds and free-list init control, paced by clk_div.
module bm_reg_bank
   import bm_reg_pkg::*;
#(
   parameter int NCNT  = 4,
   parameter int CNT_W = 16,
   parameter int NQ    = 8,
   parameter int PIO_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clk_div,
   input  logic              reg_bs,
   input  logic              reg_rd,
   input  logic              reg_wr,
   input  logic [PIO_W-1:0]  reg_addr,
   input  logic [PIO_W-1:0]  reg_din,
   output logic              pio_ack,
   output logic              pio_rvalid,
   output logic [PIO_W-1:0]  pio_rdata,
   input  logic              freeb_init_done,
   input  logic [NCNT-1:0]   cnt_inc,
   output logic              freeb_init,
   output logic [4*NQ-1:0]   dt_alpha
);

   bm_state_e        r_state;
   logic [7:0]       r_addr;
   logic             r_rd;
   logic             r_init;
   logic             r_rdsh;
   logic             r_clr;
   logic             r_sat;
   logic             r_snap;
   logic             r_done_q;
   logic [4*NQ-1:0]  r_alpha;

   logic             w_acc;
   logic             w_wr;
   logic             w_rsp;
   logic             w_rise;
   logic             w_unused;
   logic [7:0]       w_waddr;
   logic [NCNT-1:0]  w_ovf;
   logic [NCNT-1:0]  w_w1c;
   logic [NCNT-1:0]  w_clrv;
   logic [CNT_W-1:0] w_live [NCNT];
   logic [CNT_W-1:0] w_shad [NCNT];
   logic [PIO_W-1:0] w_ctrl;
   logic [PIO_W-1:0] w_rdata;

   assign w_waddr    = reg_addr[7:0];
   assign w_acc      = (r_state == ST_IDLE) && reg_bs && (reg_rd || reg_wr);
   assign w_wr       = w_acc && reg_wr;
   assign w_rsp      = (r_state == ST_WAIT) && clk_div;
   assign w_rise     = freeb_init_done && !r_done_q;
   assign w_unused   = ^{reg_addr[PIO_W-1:8], reg_din};
   assign freeb_init = r_init;
   assign dt_alpha   = r_alpha;

   for (genvar i = 0; i < NCNT; i++) begin : g_cnt
      assign w_w1c[i]  = w_wr && (w_waddr == BM_OVF) && reg_din[i];
      assign w_clrv[i] = w_rsp && r_rd && r_clr &&
                         bm_in_blk(r_addr, BM_CNT_BASE, NCNT) &&
                         (r_addr[3:0] == 4'(i));
      bm_evt_cnt #(.CNT_W(CNT_W)) u_cnt (
         .clk      (clk),
         .rst      (rst),
         .i_inc    (cnt_inc[i]),
         .i_sat    (r_sat),
         .i_clr    (w_clrv[i]),
         .i_snap   (r_snap),
         .i_w1c    (w_w1c[i]),
         .o_live   (w_live[i]),
         .o_shadow (w_shad[i]),
         .o_ovf    (w_ovf[i])
      );
   end

   always_comb begin
      w_ctrl            = '0;
      w_ctrl[CTRL_INIT] = r_init;
      w_ctrl[CTRL_RDSH] = r_rdsh;
      w_ctrl[CTRL_CLR]  = r_clr;
      w_ctrl[CTRL_SAT]  = r_sat;
      w_ctrl[CTRL_DONE] = freeb_init_done;
   end

   always_comb begin
      w_rdata = '0;
      unique case (1'b1)
         (r_addr == BM_CTRL): w_rdata = w_ctrl;
         (r_addr == BM_OVF):  w_rdata = PIO_W'(w_ovf);
         bm_in_blk(r_addr, BM_CNT_BASE, NCNT): begin
            for (int i = 0; i < NCNT; i++)
               if (r_addr[3:0] == 4'(i))
                  w_rdata = PIO_W'(r_rdsh ? w_shad[i] : w_live[i]);
         end
         bm_in_blk(r_addr, BM_ALPHA_BASE, NQ): begin
            for (int q = 0; q < NQ; q++)
               if (r_addr[3:0] == 4'(q))
                  w_rdata = PIO_W'(r_alpha[4*q +: 4]);
         end
         default: w_rdata = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= ST_IDLE;
         r_addr     <= '0;
         r_rd       <= 1'b0;
         pio_ack    <= 1'b0;
         pio_rvalid <= 1'b0;
         pio_rdata  <= '0;
         r_init     <= 1'b0;
         r_rdsh     <= 1'b0;
         r_clr      <= 1'b0;
         r_sat      <= 1'b0;
         r_snap     <= 1'b0;
         r_done_q   <= 1'b0;
         r_alpha    <= '0;
      end else begin
         r_done_q   <= freeb_init_done;
         r_snap     <= 1'b0;
         pio_ack    <= 1'b0;
         pio_rvalid <= 1'b0;
         if (w_rise)
            r_init <= 1'b0;
         unique case (r_state)
            ST_IDLE: begin
               if (w_acc) begin
                  r_addr  <= w_waddr;
                  r_rd    <= reg_rd;
                  r_state <= ST_WAIT;
               end
            end
            ST_WAIT: begin
               if (clk_div) begin
                  pio_rdata  <= r_rd ? w_rdata : '0;
                  pio_ack    <= 1'b1;
                  pio_rvalid <= r_rd;
                  r_state    <= ST_RESP;
               end
            end
            ST_RESP: r_state <= ST_IDLE;
            default: r_state <= ST_IDLE;
         endcase
         // Writes land in the accept cycle; a CTRL write beats the done-rise clear.
         if (w_wr) begin
            if (w_waddr == BM_CTRL) begin
               r_init <= reg_din[CTRL_INIT];
               r_snap <= reg_din[CTRL_SNAP];
               r_rdsh <= reg_din[CTRL_RDSH];
               r_clr  <= reg_din[CTRL_CLR];
               r_sat  <= reg_din[CTRL_SAT];
            end
            for (int q = 0; q < NQ; q++)
               if (bm_in_blk(w_waddr, BM_ALPHA_BASE, NQ) &&
                   (w_waddr[3:0] == 4'(q)))
                  r_alpha[4*q +: 4] <= reg_din[3:0];
         end
      end
   end

endmodule

// File: tb/tb_bm_reg_bank.sv
// Directed bench for bm_reg_bank with NCNT=4, CNT_W=4, NQ=8.
module tb_bm_reg_bank;

   localparam int NCNT  = 4;
   localparam int CNT_W = 4;
   localparam int NQ    = 8;
   localparam int PIO_W = 32;

   logic              clk = 1'b0;
   logic              rst;
   logic              clk_div;
   logic              reg_bs;
   logic              reg_rd;
   logic              reg_wr;
   logic [PIO_W-1:0]  reg_addr;
   logic [PIO_W-1:0]  reg_din;
   logic              pio_ack;
   logic              pio_rvalid;
   logic [PIO_W-1:0]  pio_rdata;
   logic              freeb_init_done;
   logic [NCNT-1:0]   cnt_inc;
   logic              freeb_init;
   logic [4*NQ-1:0]   dt_alpha;

   int         checks = 0;
   int         errors = 0;
   int         div_mode = 1;
   logic [1:0] div_cnt = 2'd0;

   always #5 clk = ~clk;
   always @(posedge clk) div_cnt <= div_cnt + 2'd1;
   assign clk_div = (div_mode == 0) ? 1'b1 :
                    (div_mode == 1) ? (div_cnt == 2'd3) : 1'b0;

   bm_reg_bank #(
      .NCNT(NCNT), .CNT_W(CNT_W), .NQ(NQ), .PIO_W(PIO_W)
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .clk_div         (clk_div),
      .reg_bs          (reg_bs),
      .reg_rd          (reg_rd),
      .reg_wr          (reg_wr),
      .reg_addr        (reg_addr),
      .reg_din         (reg_din),
      .pio_ack         (pio_ack),
      .pio_rvalid      (pio_rvalid),
      .pio_rdata       (pio_rdata),
      .freeb_init_done (freeb_init_done),
      .cnt_inc         (cnt_inc),
      .freeb_init      (freeb_init),
      .dt_alpha        (dt_alpha)
   );

   task automatic pio_xfer(
      input  logic        rd,
      input  logic [7:0]  a,
      input  logic [31:0] din,
      input  int          inc_idx,
      output logic [31:0] rdata,
      output logic        rvalid,
      output int          lat,
      output int          divs,
      output logic        ack_after
   );
      bit got;
      int n;
      reg_bs   = 1'b1;
      reg_rd   = rd;
      reg_wr   = !rd;
      reg_addr = {24'h0, a};
      reg_din  = din;
      @(posedge clk); #1;
      reg_bs = 1'b0;
      reg_rd = 1'b0;
      reg_wr = 1'b0;
      got = 0; n = 1; lat = 0; divs = 0;
      rdata = '0; rvalid = 1'b0; ack_after = 1'b0;
      while (!got && n < 40) begin
         if (clk_div) divs++;
         if (inc_idx >= 0) cnt_inc[inc_idx] = 1'b1;
         @(posedge clk); #1;
         cnt_inc = '0;
         n++;
         if (pio_ack) begin
            got = 1; lat = n; rdata = pio_rdata; rvalid = pio_rvalid;
         end
      end
      if (!got) begin
         checks++; errors++;
         $display("FAIL pio_timeout addr=%h got no ack required ack", a);
      end else begin
         @(posedge clk); #1;
         ack_after = pio_ack;
      end
   endtask

   task automatic rd(input logic [7:0] a, output logic [31:0] d);
      logic v, aa;
      int l, dv;
      pio_xfer(1'b1, a, 32'h0, -1, d, v, l, dv, aa);
   endtask

   task automatic wr(input logic [7:0] a, input logic [31:0] din);
      logic [31:0] d;
      logic v, aa;
      int l, dv;
      pio_xfer(1'b0, a, din, -1, d, v, l, dv, aa);
   endtask

   task automatic pulse(input int idx, input int n);
      for (int k = 0; k < n; k++) begin
         cnt_inc[idx] = 1'b1;
         @(posedge clk); #1;
      end
      cnt_inc[idx] = 1'b0;
   endtask

   task automatic test_reset();
      logic [31:0] d;
      logic v, aa;
      int l, dv;
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if ({pio_ack, pio_rvalid, pio_rdata, freeb_init, dt_alpha} !== '0) begin
         errors++;
         $display("FAIL reset_outs got ack=%b rv=%b rd=%h init=%b alpha=%h required 0",
                  pio_ack, pio_rvalid, pio_rdata, freeb_init, dt_alpha);
      end
      rst = 1'b0;
      div_mode = 1;
      pio_xfer(1'b1, 8'h00, 32'h0, -1, d, v, l, dv, aa);
      checks++;
      if (d !== 32'h0 || v !== 1'b1) begin
         errors++;
         $display("FAIL reset_ctrl_rd got data=%h rv=%b required 0/1", d, v);
      end
      checks++;
      if (dv !== 1) begin
         errors++;
         $display("FAIL ack_first_div got %0d div ticks in wait required 1", dv);
      end
      checks++;
      if (aa !== 1'b0) begin
         errors++;
         $display("FAIL ack_pulse got ack=%b after response required 0", aa);
      end
      pio_xfer(1'b0, 8'h00, 32'h0, -1, d, v, l, dv, aa);
      checks++;
      if (v !== 1'b0) begin
         errors++;
         $display("FAIL wr_rvalid got %b required 0", v);
      end
   endtask

   task automatic test_wrap();
      logic [31:0] d;
      div_mode = 0;
      wr(8'h00, 32'h0);
      pulse(1, 17);
      rd(8'h11, d);
      checks++;
      if (d !== 32'h1) begin
         errors++;
         $display("FAIL wrap_cnt got %h required 1", d);
      end
      rd(8'h01, d);
      checks++;
      if (d !== 32'h2) begin
         errors++;
         $display("FAIL wrap_ovf got %h required 2", d);
      end
      wr(8'h01, 32'h2);
      rd(8'h01, d);
      checks++;
      if (d !== 32'h0) begin
         errors++;
         $display("FAIL ovf_w1c got %h required 0", d);
      end
   endtask

   task automatic test_sat();
      logic [31:0] d;
      wr(8'h00, 32'h10);
      pulse(1, 20);
      rd(8'h11, d);
      checks++;
      if (d !== 32'hF) begin
         errors++;
         $display("FAIL sat_cnt got %h required f", d);
      end
      rd(8'h01, d);
      checks++;
      if (d !== 32'h2) begin
         errors++;
         $display("FAIL sat_ovf got %h required 2", d);
      end
      pulse(1, 1);
      rd(8'h11, d);
      checks++;
      if (d !== 32'hF) begin
         errors++;
         $display("FAIL sat_hold got %h required f", d);
      end
   endtask

   task automatic test_snap();
      logic [31:0] d;
      wr(8'h00, 32'h0);
      pulse(0, 5);
      wr(8'h00, 32'h2);
      pulse(0, 3);
      wr(8'h00, 32'h4);
      rd(8'h00, d);
      checks++;
      if (d !== 32'h4) begin
         errors++;
         $display("FAIL snap_selfclr got %h required 4", d);
      end
      rd(8'h10, d);
      checks++;
      if (d !== 32'h5) begin
         errors++;
         $display("FAIL snap_shadow got %h required 5", d);
      end
      wr(8'h00, 32'h0);
      rd(8'h10, d);
      checks++;
      if (d !== 32'h8) begin
         errors++;
         $display("FAIL snap_live got %h required 8", d);
      end
   endtask

   task automatic test_clr_on_rd();
      logic [31:0] d;
      logic v, aa;
      int l, dv;
      pulse(0, 1);
      wr(8'h00, 32'h8);
      pio_xfer(1'b1, 8'h10, 32'h0, 0, d, v, l, dv, aa);
      checks++;
      if (d !== 32'h9) begin
         errors++;
         $display("FAIL clr_first got %h required 9", d);
      end
      checks++;
      if (l !== 2) begin
         errors++;
         $display("FAIL min_latency got %0d required 2", l);
      end
      rd(8'h10, d);
      checks++;
      if (d !== 32'h1) begin
         errors++;
         $display("FAIL clr_inc got %h required 1", d);
      end
      rd(8'h10, d);
      checks++;
      if (d !== 32'h0) begin
         errors++;
         $display("FAIL clr_zero got %h required 0", d);
      end
      wr(8'h00, 32'hC);
      rd(8'h10, d);
      rd(8'h10, d);
      checks++;
      if (d !== 32'h5) begin
         errors++;
         $display("FAIL clr_shadow_kept got %h required 5", d);
      end
      wr(8'h00, 32'h0);
   endtask

   task automatic test_alpha();
      logic [31:0] d;
      wr(8'h20, 32'h5);
      wr(8'h23, 32'hA);
      checks++;
      if (dt_alpha !== 32'h0000A005) begin
         errors++;
         $display("FAIL alpha_out got %h required 0000a005", dt_alpha);
      end
      rd(8'h23, d);
      checks++;
      if (d !== 32'hA) begin
         errors++;
         $display("FAIL alpha_rd got %h required a", d);
      end
      wr(8'h40, 32'hFFFF);
      rd(8'h40, d);
      checks++;
      if (d !== 32'h0 || dt_alpha !== 32'h0000A005) begin
         errors++;
         $display("FAIL unmapped got %h alpha %h required 0 0000a005", d, dt_alpha);
      end
      rd(8'h14, d);
      checks++;
      if (d !== 32'h0) begin
         errors++;
         $display("FAIL cnt_oob got %h required 0", d);
      end
      rd(8'h28, d);
      checks++;
      if (d !== 32'h0) begin
         errors++;
         $display("FAIL alpha_oob got %h required 0", d);
      end
   endtask

   task automatic test_freeb();
      logic [31:0] d;
      wr(8'h00, 32'h1);
      checks++;
      if (freeb_init !== 1'b1) begin
         errors++;
         $display("FAIL init_set got %b required 1", freeb_init);
      end
      freeb_init_done = 1'b1;
      #1;
      checks++;
      if (freeb_init !== 1'b1) begin
         errors++;
         $display("FAIL init_hold got %b required 1", freeb_init);
      end
      @(posedge clk); #1;
      checks++;
      if (freeb_init !== 1'b0) begin
         errors++;
         $display("FAIL init_clear got %b required 0", freeb_init);
      end
      rd(8'h00, d);
      checks++;
      if (d !== 32'h80000000) begin
         errors++;
         $display("FAIL ctrl_done got %h required 80000000", d);
      end
      freeb_init_done = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      reg_bs = 1'b1; reg_wr = 1'b1; reg_addr = 32'h0; reg_din = 32'h1;
      freeb_init_done = 1'b1;
      @(posedge clk); #1;
      reg_bs = 1'b0; reg_wr = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (freeb_init !== 1'b1) begin
         errors++;
         $display("FAIL init_wr_wins got %b required 1", freeb_init);
      end
      wr(8'h00, 32'h0);
      freeb_init_done = 1'b0;
   endtask

   task automatic test_busy_rst();
      logic [31:0] d;
      int acks;
      div_mode = 2;
      reg_bs = 1'b1; reg_rd = 1'b1; reg_addr = 32'h0;
      @(posedge clk); #1;
      reg_rd = 1'b0; reg_wr = 1'b1; reg_addr = 32'h21; reg_din = 32'hF;
      @(posedge clk); #1;
      reg_bs = 1'b0; reg_wr = 1'b0;
      checks++;
      if (dt_alpha !== 32'h0000A005) begin
         errors++;
         $display("FAIL busy_ignored got %h required 0000a005", dt_alpha);
      end
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      div_mode = 0;
      acks = 0;
      repeat (5) begin
         @(posedge clk); #1;
         if (pio_ack) acks++;
      end
      checks++;
      if (acks !== 0) begin
         errors++;
         $display("FAIL rst_no_ack got %0d acks required 0", acks);
      end
      checks++;
      if (dt_alpha !== '0 || freeb_init !== 1'b0) begin
         errors++;
         $display("FAIL rst_state got alpha=%h init=%b required 0", dt_alpha, freeb_init);
      end
      rd(8'h11, d);
      checks++;
      if (d !== 32'h0) begin
         errors++;
         $display("FAIL rst_cnt got %h required 0", d);
      end
   endtask

   initial begin
      rst = 1'b1;
      reg_bs = 1'b0; reg_rd = 1'b0; reg_wr = 1'b0;
      reg_addr = '0; reg_din = '0;
      freeb_init_done = 1'b0;
      cnt_inc = '0;
      test_reset();
      test_wrap();
      test_sat();
      test_snap();
      test_clr_on_rd();
      test_alpha();
      test_freeb();
      test_busy_rst();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/bm_reg_bank.md
Name: bm_reg_bank

Overview:
- Parametrised PIO register bank for the buffer manager.
- Holds NCNT event counters, NQ per-queue 4-bit dynamic-threshold alpha registers, and the free-buffer init control.
- Adds wrap/saturate counter modes, sticky overflow status, an atomic snapshot of all counters, and optional clear-on-read.
- Sits on the PIO bus; clk_div paces responses. Counter increments come from the freeb and linked-list engines.

Parameters:
- NCNT, 4, number of event counters (1..16).
- CNT_W, 16, counter width in bits (1..32).
- NQ, 8, number of per-queue alpha registers (1..16).
- PIO_W, 32, PIO data/address width.

Ports:
- clk  in  1  core clock
- rst  in  1  reset: synchronous, active-high
- clk_div  in  1  response pacing tick, one cycle wide
- reg_bs  in  1  block select
- reg_rd  in  1  read request
- reg_wr  in  1  write request
- reg_addr  in  PIO_W  register address; bits [7:0] decoded
- reg_din  in  PIO_W  write data
- pio_ack  out  1  access complete, one-cycle pulse
- pio_rvalid  out  1  read data valid, coincident with pio_ack
- pio_rdata  out  PIO_W  registered read data
- freeb_init_done  in  1  free-list initialisation finished (level)
- cnt_inc  in  NCNT  per-counter increment strobes
- freeb_init  out  1  starts free-list initialisation
- dt_alpha  out  4*NQ  alpha for queue q at bits [4q+3:4q]

Behaviour:
- Reset: pio_ack=0, pio_rvalid=0, pio_rdata=0, freeb_init=0, dt_alpha=0. All counters, shadows and ovf bits=0. CTRL=0. FSM=IDLE.
- Address map (offset):
  - 0x00 CTRL: [0] freeb_init RW; [1] SNAP, write-1 self-clearing, reads 0; [2] RD_SHADOW; [3] CLR_ON_RD; [4] SAT; [31] freeb_init_done RO.
  - 0x01 OVF: [NCNT-1:0] sticky overflow bits, write-1-to-clear.
  - 0x10+i counter i (i<NCNT).
  - 0x20+q alpha q (q<NQ): 4 bits, RW.
  - Unmapped: writes ignored, reads return 0, ack still given.
- FSM: IDLE, WAIT, RESP.
  - IDLE: reg_bs&(reg_rd|reg_wr) accepts the request, latches addr/din/rd, goes to WAIT.
  - A write updates its register in the accept cycle.
  - WAIT: on the first clk_div=1 cycle, register pio_rdata (reads) and go to RESP.
  - RESP: pio_ack=1 for one cycle; pio_rvalid=1 if read. Return to IDLE.
  - Requests arriving while not IDLE are ignored. Minimum latency: accept to ack is 2 cycles.
- Reads:
  - Counter read value = shadow[i] if RD_SHADOW else live[i], zero-extended to PIO_W.
  - CLR_ON_RD clears live[i] in the WAIT->RESP cycle. If cnt_inc[i] is set in that cycle, live[i]=1. Shadow is never cleared by a read.
- Counters:
  - Each cycle with cnt_inc[i]=1: at max value (2^CNT_W-1), SAT=1 holds at max, SAT=0 wraps to 0. Either way ovf[i] is set.
  - An ovf set and a W1C in the same cycle: set wins.
- SNAP: shadow[i] <= live[i] for all i in the cycle after the CTRL write. Increments in that cycle land in live only.
- freeb_init: written via CTRL[0]. Hardware clears it in the cycle after freeb_init_done rises (0->1). If a write of 1 coincides with that rise, the write wins.
- rst mid-transaction: FSM returns to IDLE, no ack is issued, all state is reset.

Decomposition:
- Package bm_reg_pkg holds:
  - Address offsets: BM_CTRL, BM_OVF, BM_CNT_BASE, BM_ALPHA_BASE.
  - CTRL bit indices.
  - FSM state encoding.
- Sub-module bm_evt_cnt, instantiated NCNT times: CNT_W live counter, shadow, sat/wrap, clear, sticky ovf, W1C input.

Test Plan:
- Reset, then read 0x00 with clk_div every 4th cycle -> pio_ack and pio_rvalid together, one cycle, on the first clk_div after accept; pio_rdata=0.
- CNT_W=4, SAT=0, 17 pulses on cnt_inc[1] -> counter 1 reads 1; OVF reads 0x2; write OVF=0x2 then read -> 0.
- SAT=1, 20 pulses with CNT_W=4 -> counter reads 15, ovf[1]=1; a further increment leaves 15.
- 5 increments on cnt_inc[0], SNAP, 3 more, read with RD_SHADOW=1 -> 5; with RD_SHADOW=0 -> 8.
- CLR_ON_RD=1, counter 0=9, read with cnt_inc[0] high in the clear cycle -> read returns 9; next read returns 1.
- Write 0x23=0xA -> dt_alpha[15:12]=0xA, other queues unchanged. Write CTRL[0]=1 -> freeb_init=1; raise freeb_init_done -> freeb_init=0 next cycle; CTRL reads 0x80000000.
